// File: rtl/mod_counter.sv
// Modulo-MODULUS up/down counter with clear, load, terminal count for cascading,
// a one-cycle load-range error flag and a saturating wrap-event counter.
module mod_counter #(
    parameter int WIDTH   = 4,
    parameter int MODULUS = 11,
    parameter int WRAP_W  = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              en,
    input  logic              up,
    input  logic              clr,
    input  logic              load,
    input  logic [WIDTH-1:0]  din,
    output logic [WIDTH-1:0]  count,
    output logic              tc,
    output logic              err,
    output logic [WRAP_W-1:0] wrap_cnt
);

    localparam logic [WIDTH-1:0]  TOP_VAL  = WIDTH'(MODULUS - 1);
    localparam logic [WIDTH:0]    TOP_EXT  = (WIDTH + 1)'(MODULUS - 1);
    localparam logic [WRAP_W-1:0] WRAP_MAX = '1;

    logic              at_top;
    logic              at_zero;
    logic              din_bad;
    logic [WIDTH-1:0]  count_next;
    logic              err_next;
    logic [WRAP_W-1:0] wrap_next;

    assign at_top  = (count == TOP_VAL);
    assign at_zero = (count == '0);
    // Extra bit so that MODULUS = 2^WIDTH never flags any din as out of range.
    assign din_bad = ({1'b0, din} > TOP_EXT);

    // tc is exactly "this edge wraps", so it doubles as the wrap event.
    assign tc = en & ~clr & ~load & ((up & at_top) | (~up & at_zero));

    always_comb begin
        // NOTE: every output of this block gets a default first, so no path can infer a latch.
        count_next = count;
        err_next   = 1'b0;
        wrap_next  = wrap_cnt;
        if (clr) begin
            count_next = '0;
            wrap_next  = '0;
        end else if (load) begin
            if (din_bad) begin
                count_next = TOP_VAL;
                err_next   = 1'b1;
            end else begin
                count_next = din;
            end
        end else if (en) begin
            if (up) begin
                count_next = at_top ? '0 : count + 1'b1;
            end else begin
                count_next = at_zero ? TOP_VAL : count - 1'b1;
            end
            if (tc && (wrap_cnt != WRAP_MAX)) begin
                wrap_next = wrap_cnt + 1'b1;
            end
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count    <= '0;
            err      <= 1'b0;
            wrap_cnt <= '0;
        end else begin
            count    <= count_next;
            err      <= err_next;
            wrap_cnt <= wrap_next;
        end
    end

endmodule

// File: tb/tb_mod_counter.sv
// Self-checking bench for mod_counter: directed scenarios plus random traffic
// compared against an arithmetic reference model, on several parameter sets.
module tb_mod_counter;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       en, up, clr, load;
    logic [3:0] din;
    logic       c_en;

    logic [3:0] count_a, count_b, count_c, ones, tens;
    logic       tc_a, tc_b, tc_c, tc_o, tc_t;
    logic       err_a, err_b, err_c, err_o, err_t;
    logic [7:0] wrap_a, wrap_c, wrap_o, wrap_t;
    logic [1:0] wrap_b;

    int vectors = 0;
    int miscompares = 0;

    int m_cnt11, m_wr11, m_cnt16, m_wr16, c_total;
    bit m_err11, m_err16;

    always #5 clk = ~clk;

    mod_counter #(.WIDTH(4), .MODULUS(11), .WRAP_W(8)) dut_a (
        .clk(clk), .rst_n(rst_n), .en(en), .up(up), .clr(clr), .load(load), .din(din),
        .count(count_a), .tc(tc_a), .err(err_a), .wrap_cnt(wrap_a));

    mod_counter #(.WIDTH(4), .MODULUS(11), .WRAP_W(2)) dut_b (
        .clk(clk), .rst_n(rst_n), .en(en), .up(up), .clr(clr), .load(load), .din(din),
        .count(count_b), .tc(tc_b), .err(err_b), .wrap_cnt(wrap_b));

    mod_counter #(.WIDTH(4), .MODULUS(16), .WRAP_W(8)) dut_c (
        .clk(clk), .rst_n(rst_n), .en(en), .up(up), .clr(clr), .load(load), .din(din),
        .count(count_c), .tc(tc_c), .err(err_c), .wrap_cnt(wrap_c));

    mod_counter #(.WIDTH(4), .MODULUS(10), .WRAP_W(8)) dut_ones (
        .clk(clk), .rst_n(rst_n), .en(c_en), .up(1'b1), .clr(1'b0), .load(1'b0), .din(4'd0),
        .count(ones), .tc(tc_o), .err(err_o), .wrap_cnt(wrap_o));

    mod_counter #(.WIDTH(4), .MODULUS(10), .WRAP_W(8)) dut_tens (
        .clk(clk), .rst_n(rst_n), .en(tc_o), .up(1'b1), .clr(1'b0), .load(1'b0), .din(4'd0),
        .count(tens), .tc(tc_t), .err(err_t), .wrap_cnt(wrap_t));

    task automatic check(input string tag, input int got, input int exp);
        vectors++;
        if (got != exp) begin
            miscompares++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    // Would the coming edge leave the 0..mod-1 range and wrap?
    function automatic int will_wrap(input int mod, input logic e, u, c, l, input int cnt);
        if (!e || c || l) return 0;
        return u ? int'(cnt + 1 >= mod) : int'(cnt - 1 < 0);
    endfunction

    function automatic int sat(input int v, input int w);
        return (v > (1 << w) - 1) ? (1 << w) - 1 : v;
    endfunction

    task automatic step_model(input int mod, input logic e, u, c, l, input logic [3:0] d,
                              inout int cnt, inout int wr, output bit er);
        er = 1'b0;
        if (c) begin
            cnt = 0;
            wr  = 0;
        end else if (l) begin
            if (int'(d) < mod) cnt = int'(d);
            else begin
                cnt = mod - 1;
                er  = 1'b1;
            end
        end else if (e) begin
            cnt = u ? cnt + 1 : cnt - 1;
            if (cnt >= mod || cnt < 0) begin
                cnt = (cnt + mod) % mod;
                wr++;
            end
        end
    endtask

    task automatic model_reset();
        m_cnt11 = 0; m_wr11 = 0; m_err11 = 0;
        m_cnt16 = 0; m_wr16 = 0; m_err16 = 0;
        c_total = 0;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_cnt_a"}, count_a, 0); check({tag, "_err_a"}, err_a, 0);
        check({tag, "_wrap_a"}, wrap_a, 0); check({tag, "_tc_a"}, tc_a, 0);
        check({tag, "_cnt_b"}, count_b, 0); check({tag, "_wrap_b"}, wrap_b, 0);
        check({tag, "_cnt_c"}, count_c, 0); check({tag, "_wrap_c"}, wrap_c, 0);
        check({tag, "_ones"}, ones, 0); check({tag, "_tens"}, tens, 0);
    endtask

    task automatic apply(input logic e, u, c, l, input logic [3:0] d);
        int o_wrap;
        @(negedge clk);
        en = e; up = u; clr = c; load = l; din = d;
        #1;
        o_wrap = will_wrap(10, c_en, 1'b1, 1'b0, 1'b0, c_total % 10);
        check("tc_a", tc_a, will_wrap(11, e, u, c, l, m_cnt11));
        check("tc_b", tc_b, will_wrap(11, e, u, c, l, m_cnt11));
        check("tc_c", tc_c, will_wrap(16, e, u, c, l, m_cnt16));
        check("tc_ones", tc_o, o_wrap);
        check("tc_tens", tc_t, will_wrap(10, o_wrap[0], 1'b1, 1'b0, 1'b0, (c_total / 10) % 10));
        @(posedge clk);
        step_model(11, e, u, c, l, d, m_cnt11, m_wr11, m_err11);
        step_model(16, e, u, c, l, d, m_cnt16, m_wr16, m_err16);
        if (c_en) c_total = (c_total + 1) % 100;
        #1;
        check("count_a", count_a, m_cnt11);
        check("err_a", err_a, m_err11);
        check("wrap_a", wrap_a, sat(m_wr11, 8));
        check("count_b", count_b, m_cnt11);
        check("err_b", err_b, m_err11);
        check("wrap_b", wrap_b, sat(m_wr11, 2));
        check("count_c", count_c, m_cnt16);
        check("err_c", err_c, m_err16);
        check("wrap_c", wrap_c, sat(m_wr16, 8));
        check("ones", ones, c_total % 10);
        check("tens", tens, c_total / 10);
    endtask

    initial begin
        rst_n = 1'b0;
        en = 0; up = 0; clr = 0; load = 0; din = '0; c_en = 1'b0;
        model_reset();
        #12;
        check_all_zero("reset");
        #8 rst_n = 1'b1;

        // Count up through one wrap.
        repeat (12) apply(1, 1, 0, 0, 4'd0);
        check("up_final_count", count_a, 1);
        check("up_final_wrap", wrap_a, 1);

        // Load 2, count down through zero.
        apply(0, 0, 0, 1, 4'd2);
        repeat (4) apply(1, 0, 0, 0, 4'd0);
        check("down_final_count", count_a, 9);
        check("down_final_wrap", wrap_a, 2);

        // Load range and one-cycle error pulse.
        apply(0, 0, 0, 1, 4'd7);
        check("load7_count", count_a, 7);
        check("load7_err", err_a, 0);
        apply(0, 0, 0, 1, 4'd13);
        check("load13_count", count_a, 10);
        check("load13_err", err_a, 1);
        check("load13_err_m16", err_c, 0);
        apply(0, 0, 0, 0, 4'd0);
        check("err_clears", err_a, 0);

        // clr beats load and en; tc is checked inside apply before the edge.
        apply(1, 1, 1, 1, 4'd13);
        check("prio_count", count_a, 0);
        check("prio_err", err_a, 0);
        check("prio_wrap", wrap_a, 0);

        // Five up-wraps: 2-bit wrap counter saturates at 3.
        repeat (55) apply(1, 1, 0, 0, 4'd0);
        check("sat_wrap_b", wrap_b, 3);
        check("sat_wrap_a", wrap_a, 5);

        // Two-stage decimal cascade.
        c_en = 1'b1;
        repeat (25) apply(0, 0, 0, 0, 4'd0);
        c_en = 1'b0;
        check("cascade_ones", ones, 5);
        check("cascade_tens", tens, 2);

        // Asynchronous reset between edges.
        repeat (3) apply(1, 1, 0, 0, 4'd0);
        @(negedge clk);
        en = 1'b0;
        #2 rst_n = 1'b0;
        #1 check_all_zero("async_rst");
        model_reset();
        #1 rst_n = 1'b1;
        apply(1, 1, 0, 0, 4'd0);
        check("first_edge_count", count_a, 1);

        // Random traffic.
        for (int i = 0; i < 400; i++) begin
            c_en = 1'($urandom_range(0, 1));
            apply(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)),
                  1'($urandom_range(0, 31) == 0), 1'($urandom_range(0, 7) == 0),
                  4'($urandom_range(0, 15)));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
